// File: rtl/uart_rx_loader.sv
// UART receive-and-load engine: deserialises rx, packs bytes little-endian into words, and emits each word with its address.
// Latency: 3 clk pin-to-detect; word_valid is registered and fires the cycle after the final stop sample of the completing byte.
// Backpressure: none; word_valid is a one-cycle strobe that the consumer must take when it fires.
module uart_rx_loader #(
    parameter int BPS_CNT    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int WORD_BYTES = 4,
    parameter int MAX_WORDS  = 16384,
    parameter int MAX_IDLE   = 2000,
    parameter int ADDR_W     = $clog2(MAX_WORDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic [ADDR_W-1:0]       addr,
    output logic                    word_valid,
    output logic                    done,
    output logic                    parity_err,
    output logic                    frame_err
);
    localparam int CW  = $clog2(BPS_CNT);
    localparam int IW  = $clog2(MAX_IDLE + 1);
    localparam int WW  = 8 * WORD_BYTES;
    localparam int AW1 = ADDR_W + 1;
    localparam logic [CW-1:0]  HALF_M1  = CW'(BPS_CNT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1  = CW'(BPS_CNT - 1);
    localparam logic [IW-1:0]  IDLE_MAX = IW'(MAX_IDLE);
    localparam logic [IW-1:0]  IDLE_M1  = IW'(MAX_IDLE - 1);
    localparam logic [AW1-1:0] WORDS_M1 = AW1'(MAX_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t          state_q, state_d;
    logic            rx_s1_q, rx_s2_q, rx_h_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      data_q;
    logic            bad_q;
    logic [1:0]      lane_q;
    logic [WW-1:0]   pend_q;
    logic [AW1-1:0]  words_q;
    logic            armed_q, flush_q;
    logic [CW-1:0]   idle_clk_q;
    logic [IW-1:0]   idle_bits_q;
    logic [WW-1:0]   word_out_q;
    logic [ADDR_W-1:0] addr_q;
    logic            word_valid_q, done_q, parity_err_q, frame_err_q;

    logic            start_cand, tick, par_exp, accept, timeout, last_lane;
    logic [WW-1:0]   new_word;

    // Once done is set (or a flush is completing) rx is ignored entirely.
    assign start_cand = rx_h_q & ~rx_s2_q & ~done_q & ~flush_q;
    assign tick       = (state_q == S_START) ? (bit_cnt_q == HALF_M1) : (bit_cnt_q == FULL_M1);
    assign par_exp    = (PARITY == 2) ? ^data_q : ~^data_q;
    assign accept     = (state_q == S_STOP) & tick & rx_s2_q & (bit_idx_q == 3'(STOP_BITS - 1)) & ~bad_q;
    assign last_lane  = (lane_q == 2'(WORD_BYTES - 1));
    assign new_word   = pend_q | (WW'(data_q) << {lane_q, 3'b000});
    // A start candidate in the saturating cycle wins over the timeout.
    assign timeout    = (state_q == S_IDLE) & armed_q & ~done_q & ~flush_q & ~start_cand
                      & (idle_clk_q == FULL_M1) & (idle_bits_q == IDLE_M1);

    // Two-flop synchroniser plus history flop for edge detection; idle-high reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_h_q  <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_h_q  <= rx_s2_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic: sample points come from tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_cand) state_d = S_START;
            S_START:  if (tick) state_d = rx_s2_q ? S_IDLE : S_DATA;
            S_DATA:   if (tick && bit_idx_q == 3'(DATA_BITS - 1))
                          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (tick) state_d = S_STOP;
            S_STOP:   if (tick) begin
                          if (!rx_s2_q) state_d = S_BREAK;
                          else if (bit_idx_q == 3'(STOP_BITS - 1)) state_d = S_IDLE;
                      end
            S_BREAK:  if (rx_s2_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Clock-within-bit and bit-index counters, restarted on every state change.
    always_ff @(posedge clk) begin
        if (reset || state_d != state_q) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
        end else begin
            if (tick) bit_cnt_q <= '0;
            else if (state_q != S_IDLE && state_q != S_BREAK) bit_cnt_q <= bit_cnt_q + 1'b1;
            if (tick && (state_q == S_DATA || state_q == S_STOP)) bit_idx_q <= bit_idx_q + 1'b1;
        end
    end

    // Character shift-in, parity/frame checking and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= '0;
            bad_q        <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && state_d == S_START) begin
                data_q <= '0;
                bad_q  <= 1'b0;
            end
            if (state_q == S_DATA && tick) data_q[bit_idx_q] <= rx_s2_q;
            if (state_q == S_PARITY && tick && rx_s2_q != par_exp) begin
                bad_q        <= 1'b1;
                parity_err_q <= 1'b1;
            end
            if (state_q == S_STOP && tick && !rx_s2_q) frame_err_q <= 1'b1;
        end
    end

    // Lane packing, word emission, partial-word flush and done generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q       <= '0;
            pend_q       <= '0;
            words_q      <= '0;
            armed_q      <= 1'b0;
            flush_q      <= 1'b0;
            word_out_q   <= '0;
            addr_q       <= '0;
            word_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            flush_q      <= 1'b0;
            if (flush_q) done_q <= 1'b1;
            if (accept) begin
                armed_q <= 1'b1;
                if (last_lane) begin
                    word_out_q   <= new_word;
                    addr_q       <= words_q[ADDR_W-1:0];
                    word_valid_q <= 1'b1;
                    words_q      <= words_q + 1'b1;
                    pend_q       <= '0;
                    lane_q       <= '0;
                    if (words_q == WORDS_M1) done_q <= 1'b1;
                end else begin
                    pend_q <= new_word;
                    lane_q <= lane_q + 1'b1;
                end
            end else if (timeout) begin
                if (lane_q != 2'd0) begin
                    word_out_q   <= pend_q;
                    addr_q       <= words_q[ADDR_W-1:0];
                    word_valid_q <= 1'b1;
                    words_q      <= words_q + 1'b1;
                    pend_q       <= '0;
                    lane_q       <= '0;
                    flush_q      <= 1'b1;
                end else begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Idle timer in bit-times; armed by the first accepted byte, saturating.
    always_ff @(posedge clk) begin
        if (reset || start_cand) begin
            idle_clk_q  <= '0;
            idle_bits_q <= '0;
        end else if (state_q == S_IDLE && armed_q && idle_bits_q != IDLE_MAX) begin
            if (idle_clk_q == FULL_M1) begin
                idle_clk_q  <= '0;
                idle_bits_q <= idle_bits_q + 1'b1;
            end else begin
                idle_clk_q <= idle_clk_q + 1'b1;
            end
        end
    end

    assign word_out   = word_out_q;
    assign addr       = addr_q;
    assign word_valid = word_valid_q;
    assign done       = done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader: three instances (8N1, even parity, two-word limit) share clk, reset and rx.
// A negedge monitor logs every word_valid pulse with its data, address and cycle; checks read those logs.
// Stimulus is serial characters driven bit by bit, with expected words computed by hand.
`timescale 1ns/1ps
module tb_uart_rx_loader;
    localparam int BPS = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wo [3];
    logic [13:0] ad [3];
    logic        wv [3];
    logic        dn [3];
    logic        pe [3];
    logic        fe [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_rx_loader #(
            .BPS_CNT(BPS), .DATA_BITS(8), .PARITY((g == 1) ? 2 : 0), .STOP_BITS(1),
            .WORD_BYTES(4), .MAX_WORDS((g == 2) ? 2 : 16384), .MAX_IDLE(20), .ADDR_W(14)
        ) u_dut (
            .clk(clk), .reset(reset), .rx(rx), .word_out(wo[g]), .addr(ad[g]),
            .word_valid(wv[g]), .done(dn[g]), .parity_err(pe[g]), .frame_err(fe[g])
        );
    end

    logic [31:0] mdat [3][64];
    logic [13:0] madr [3][64];
    int          mcyc [3][64];
    int          mn [3]    = '{default: 0};
    int          mwide [3] = '{default: 0};
    int          dcyc [3]  = '{default: -1};
    logic        pwv [3]   = '{default: 1'b0};
    logic        pdn [3]   = '{default: 1'b0};

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (wv[g] === 1'b1) begin
                if (mn[g] < 64) begin
                    mdat[g][mn[g]] = wo[g];
                    madr[g][mn[g]] = ad[g];
                    mcyc[g][mn[g]] = cyc;
                end
                mn[g]++;
                if (pwv[g] === 1'b1) mwide[g]++;
            end
            if (dn[g] === 1'b1 && pdn[g] !== 1'b1) dcyc[g] = cyc;
            pwv[g] = wv[g];
            pdn[g] = dn[g];
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BPS) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int par, input logic flip, input int stop_low);
        logic p;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par != 0) begin
            p = (par == 2) ? ^d : ~^d;
            drive_bit(p ^ flip);
        end
        repeat (stop_low) drive_bit(1'b0);
        drive_bit(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx = 1'b1;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
    endtask

    task automatic wait_words(input int g, input int target, input int budget, input string tag);
        int k = 0;
        while (mn[g] < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, mn[g], target);
    endtask

    initial begin
        int b;
        idle(4);
        reset = 1'b0;
        idle(3);

        // Reset state
        check("rst_word", wo[0], 32'h0);
        check("rst_addr", 32'(ad[0]), 32'h0);
        check("rst_valid", 32'(wv[0]), 32'h0);
        check("rst_done", 32'(dn[0]), 32'h0);
        check("rst_perr", 32'(pe[0]), 32'h0);
        check("rst_ferr", 32'(fe[0]), 32'h0);

        // Four bytes make a word; the fifth is flushed on idle timeout, done follows one cycle later
        b = mn[0];
        send(8'h78, 0, 1'b0, 0);
        send(8'h56, 0, 1'b0, 0);
        send(8'h34, 0, 1'b0, 0);
        send(8'h12, 0, 1'b0, 0);
        send(8'hEF, 0, 1'b0, 0);
        wait_words(0, b + 2, 1000, "t1_nwords");
        check("t1_w0", mdat[0][b], 32'h12345678);
        check("t1_a0", 32'(madr[0][b]), 32'd0);
        check("t1_w1_flush", mdat[0][b+1], 32'h000000EF);
        check("t1_a1", 32'(madr[0][b+1]), 32'd1);
        idle(3);
        check("t1_done", 32'(dn[0]), 32'd1);
        check("t1_done_lat", 32'(dcyc[0] - mcyc[0][b+1]), 32'd1);
        check("t1_flags", {30'd0, pe[0], fe[0]}, 32'd0);

        // Back-to-back characters with no gap
        do_reset();
        b = mn[0];
        for (int i = 0; i < 8; i++) send(8'(8'h11 * (i + 1)), 0, 1'b0, 0);
        wait_words(0, b + 2, 100, "t2_nwords");
        check("t2_w0", mdat[0][b], 32'h44332211);
        check("t2_a0", 32'(madr[0][b]), 32'd0);
        check("t2_w1", mdat[0][b+1], 32'h88776655);
        check("t2_a1", 32'(madr[0][b+1]), 32'd1);
        check("t2_flags", {30'd0, pe[0], fe[0]}, 32'd0);

        // Short low glitch is a false start
        do_reset();
        b = mn[0];
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * BPS);
        check("t3_glitch_nowv", 32'(mn[0] - b), 32'd0);
        check("t3_glitch_flags", {30'd0, pe[0], fe[0]}, 32'd0);
        send(8'hA5, 0, 1'b0, 0);
        wait_words(0, b + 1, 1000, "t3_nwords");
        check("t3_w0", mdat[0][b], 32'h000000A5);
        check("t3_a0", 32'(madr[0][b]), 32'd0);

        // Even parity: a bad-parity byte is dropped without shifting the lanes
        do_reset();
        b = mn[1];
        send(8'h01, 2, 1'b1, 0);
        send(8'h11, 2, 1'b0, 0);
        send(8'h22, 2, 1'b0, 0);
        send(8'h33, 2, 1'b0, 0);
        send(8'h44, 2, 1'b0, 0);
        wait_words(1, b + 1, 100, "t4_nwords");
        check("t4_w0", mdat[1][b], 32'h44332211);
        check("t4_a0", 32'(madr[1][b]), 32'd0);
        check("t4_perr", 32'(pe[1]), 32'd1);
        check("t4_ferr", 32'(fe[1]), 32'd0);

        // Stop bit held low: frame error, char dropped, receiver recovers
        do_reset();
        b = mn[0];
        send(8'h55, 0, 1'b0, 3);
        check("t5_ferr", 32'(fe[0]), 32'd1);
        send(8'hDE, 0, 1'b0, 0);
        send(8'hAD, 0, 1'b0, 0);
        send(8'hBE, 0, 1'b0, 0);
        send(8'hEF, 0, 1'b0, 0);
        wait_words(0, b + 1, 100, "t5_nwords");
        check("t5_w0", mdat[0][b], 32'hEFBEADDE);
        check("t5_a0", 32'(madr[0][b]), 32'd0);
        check("t5_perr", 32'(pe[0]), 32'd0);

        // Word limit: done with the second word, ninth byte ignored
        do_reset();
        b = mn[2];
        for (int i = 0; i < 9; i++) send(8'(i + 1), 0, 1'b0, 0);
        wait_words(2, b + 2, 100, "t6_nwords");
        check("t6_w0", mdat[2][b], 32'h04030201);
        check("t6_w1", mdat[2][b+1], 32'h08070605);
        check("t6_a1", 32'(madr[2][b+1]), 32'd1);
        check("t6_done_same", 32'(dcyc[2] - mcyc[2][b+1]), 32'd0);
        idle(25 * BPS);
        check("t6_ignored", 32'(mn[2] - b), 32'd2);
        check("t6_done", 32'(dn[2]), 32'd1);

        // Reset in the middle of a character
        fork
            send(8'hF0, 0, 1'b0, 0);
            begin
                idle(6 * BPS + 4);
                reset = 1'b1;
                idle(3);
                reset = 1'b0;
            end
        join
        idle(2);
        check("t6_rst_word", wo[2], 32'h0);
        check("t6_rst_addr", 32'(ad[2]), 32'h0);
        check("t6_rst_done", 32'(dn[2]), 32'h0);
        check("t6_rst_flags", {29'd0, wv[2], pe[2], fe[2]}, 32'h0);
        b = mn[2];
        send(8'hA1, 0, 1'b0, 0);
        send(8'hB2, 0, 1'b0, 0);
        send(8'hC3, 0, 1'b0, 0);
        send(8'hD4, 0, 1'b0, 0);
        wait_words(2, b + 1, 100, "t6_post_nwords");
        check("t6_post_w0", mdat[2][b], 32'hD4C3B2A1);
        check("t6_post_a0", 32'(madr[2][b]), 32'd0);

        check("valid_width_a", 32'(mwide[0]), 32'd0);
        check("valid_width_c", 32'(mwide[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_loader.md
# uart_rx_loader

Parametrised UART receive-and-load engine. It deserialises an asynchronous serial line into bytes, packs the bytes little-endian into words, and emits each word with a sequential word address for writing program/data memory at boot. It replaces the fixed 8N1 receiver with configurable baud divisor, data bits, parity, stop bits and word width. It adds mid-bit sampling, false-start rejection, error flags and partial-word flush on idle timeout.

## Interface
- BPS_CNT, 868: clocks per bit (100 MHz / 115200); must be at least 8.
- DATA_BITS, 8: data bits per character, 5..8; unused upper byte bits are 0.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- WORD_BYTES, 4: bytes per emitted word, 1..4.
- MAX_WORDS, 16384: word limit; reaching it raises done.
- MAX_IDLE, 2000: idle bit-times after the first byte before done.
- ADDR_W, $clog2(MAX_WORDS): address width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rx  in  1  asynchronous serial input, idle high.
- word_out  out  8*WORD_BYTES  assembled word, valid while word_valid is high and held afterwards.
- addr  out  ADDR_W  word index of word_out.
- word_valid  out  1  one-cycle strobe.
- done  out  1  sticky load-complete flag.
- parity_err  out  1  sticky.
- frame_err  out  1  sticky.

## Operation
- rx passes through a 2-flop synchroniser plus one history flop. A start candidate is a synchronised 1→0 edge while in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE → START on start candidate; the bit counter is cleared.
- START: wait BPS_CNT/2 clocks, then sample.
  - Sample 1: false start; return to IDLE with no flags.
  - Sample 0: go to DATA.
- DATA: sample every BPS_CNT clocks, LSB first, DATA_BITS samples.
  - Go to PARITY if PARITY≠0, else to STOP.
- PARITY: one sample.
  - Mismatch marks the character bad and sets parity_err.
- STOP: STOP_BITS samples.
  - Any stop sample 0 sets frame_err, drops the character and goes to BREAK.
  - Otherwise the character is accepted (unless marked bad) and the FSM returns to IDLE.
  - IDLE is entered right after the last stop sample, so back-to-back characters are received.
- BREAK: wait for synchronised rx = 1, then go to IDLE.
- Bad characters are dropped: they are not packed and do not advance the byte lane.
- Packing: the accepted byte k of a word goes to word_out[8k+7:8k].
  - When lane WORD_BYTES−1 is filled, word_valid pulses and addr = current word count.
  - The count increments after the pulse.
- Idle timer:
  - Counts bit-times (BPS_CNT clocks each) while the FSM is in IDLE.
  - Clears on any start candidate.
  - Armed only after the first accepted byte.
  - Saturates at MAX_IDLE.
- done rises when either:
  - the word count reaches MAX_WORDS, or
  - the idle timer reaches MAX_IDLE.
- Idle timeout with a partial word pending:
  - The word is flushed zero-padded in the upper lanes with a word_valid pulse.
  - done rises the following cycle.
- Once done = 1, the receiver ignores rx until reset; no further word_valid pulses occur.
- The error flags never block reception of later characters.

## Timing
- Reset values: word_out = 0, addr = 0, word_valid = 0, done = 0, parity_err = 0, frame_err = 0. The FSM enters IDLE; the timer, lanes and word count clear.
- Reset mid-character aborts it with no outputs; the next full character is received normally.
- Pin-to-detect latency: 3 clk. Data samples fall at start-detect + BPS_CNT/2 + n·BPS_CNT, with n = 1..DATA_BITS.
- word_valid asserts the cycle after the final stop sample of the completing byte. It is high for exactly 1 clk.
- Error flags assert in the cycle after the offending sample.
- Word count reaching MAX_WORDS: done asserts in the same cycle as that word_valid.
- Idle timeout: the flush word_valid fires in cycle T; done asserts at T+1.
  - With no partial word pending, done asserts when the timer saturates.
- A start candidate in the same cycle the timer would saturate wins: the timer clears and done does not rise.

## Test plan
- BPS_CNT = 16, 8N1, WORD_BYTES = 4; send 0x78, 0x56, 0x34, 0x12, 0xEF.
  - Expect word_valid with word_out = 0x12345678, addr = 0.
  - After MAX_IDLE bit-times, expect a flush with 0x000000EF, addr = 1, then done = 1 one cycle later.
- Back-to-back 8 bytes with no inter-character gap → two words at addr 0 and 1, no error flags.
- rx low pulse of 4 clk (BPS_CNT/4) → no word_valid, no flags, FSM back in IDLE; a following byte 0xA5 is received correctly.
- PARITY = 2; send 0x01 with parity bit 0 (wrong), then 0x11, 0x22, 0x33, 0x44 correct.
  - Expect parity_err = 1 and word_out = 0x44332211.
- Stop bit held low for 3 bit-times → frame_err = 1 and no reception until rx is high; the next 4 bytes form a word normally.
- MAX_WORDS = 2; send 9 bytes.
  - Expect done = 1 with the second word_valid and the 9th byte ignored.
  - Then assert reset mid-byte: all outputs go to 0, and a subsequent 4-byte word appears at addr 0.
